// File: rtl/alu_cmd_issuer.sv
// Command issuer for a combinational ALU: latches a command, waits one settle
// cycle, captures the ALU result plus flags into a small result FIFO.
module alu_cmd_issuer #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [BITS-1:0]            i_cmd_a,
    input  logic [BITS-1:0]            i_cmd_b,
    input  logic [1:0]                 i_cmd_op,
    output logic [BITS-1:0]            o_alu_a,
    output logic [BITS-1:0]            o_alu_b,
    output logic [1:0]                 o_alu_op,
    input  logic [BITS-1:0]            i_alu_out,
    input  logic                       i_alu_carry,
    input  logic                       i_alu_err,
    input  logic                       i_alu_even,
    input  logic                       i_alu_single,
    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic [BITS-1:0]            o_res_data,
    output logic [1:0]                 o_res_op,
    output logic [3:0]                 o_res_flags,
    output logic                       o_busy,
    output logic [$clog2(DEPTH):0]     o_res_count,
    output logic [7:0]                 o_err_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = BITS + 6;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] alu_a_q, alu_a_d;
    logic [BITS-1:0] alu_b_q, alu_b_d;
    logic [1:0]      alu_op_q, alu_op_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic            accept_c;
    logic            pop_c;
    logic            wr_c;
    logic [EW-1:0]   head_c;

    assign o_cmd_ready = (state_q == IDLE) && (count_q < CW'(DEPTH));
    assign o_res_valid = (count_q != '0);
    assign accept_c    = i_cmd_valid & o_cmd_ready;
    assign pop_c       = o_res_valid & i_res_ready;
    assign wr_c        = (state_q == CAPTURE);
    assign head_c      = mem_q[rd_ptr_q];

    // Head entry is masked to zero whenever the FIFO is empty
    assign o_res_data  = o_res_valid ? head_c[EW-1 -: BITS] : '0;
    assign o_res_op    = o_res_valid ? head_c[5:4] : 2'b00;
    assign o_res_flags = o_res_valid ? head_c[3:0] : 4'b0000;
    assign o_busy      = (state_q != IDLE);
    assign o_res_count = count_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_alu_a     = alu_a_q;
    assign o_alu_b     = alu_b_q;
    assign o_alu_op    = alu_op_q;

    // Next-state, operand latch and FIFO update
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    alu_a_d  = i_cmd_a;
                    alu_b_d  = i_cmd_b;
                    alu_op_d = i_cmd_op;
                    state_d  = ISSUE;
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (wr_c) begin
            mem_d[wr_ptr_q] = {i_alu_out, alu_op_q, i_alu_carry, i_alu_err,
                               i_alu_even, i_alu_single};
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (i_alu_err && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end

        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (wr_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (pop_c && !wr_c) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= 2'b00;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 The block SHALL have parameter BITS, default 8, meaning operand/result width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning result FIFO entries (power of two, >=2).
REQ-003 The block SHALL have port i_clk  input  1  single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports i_cmd_valid input 1, o_cmd_ready output 1, meaning command handshake.
REQ-006 The block SHALL have ports i_cmd_a input BITS, i_cmd_b input BITS, i_cmd_op input 2, meaning command operands and opcode.
REQ-007 The block SHALL have ports o_alu_a output BITS, o_alu_b output BITS, o_alu_op output 2, meaning operands driven to the combinational ALU.
REQ-008 The block SHALL have ports i_alu_out input BITS, i_alu_carry, i_alu_err, i_alu_even, i_alu_single input 1 each, meaning ALU results.
REQ-009 The block SHALL have ports o_res_valid output 1, i_res_ready input 1, meaning result handshake.
REQ-010 The block SHALL have ports o_res_data output BITS, o_res_op output 2, o_res_flags output 4 ({carry,err,even,single}), meaning FIFO head entry.
REQ-011 The block SHALL have ports o_busy output 1, o_res_count output $clog2(DEPTH)+1, o_err_cnt output 8, meaning status.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, CAPTURE; encoding free.
REQ-013 o_cmd_ready SHALL be 1 only in IDLE with o_res_count < DEPTH; combinational from state and count.
REQ-014 Accept = i_cmd_valid & o_cmd_ready at a rising edge; on accept, i_cmd_a/b/op SHALL be registered onto o_alu_a/b/op and state -> ISSUE.
REQ-015 ISSUE SHALL last exactly one cycle (ALU settle), then -> CAPTURE unconditionally.
REQ-016 In CAPTURE, at the closing edge, {i_alu_out, o_alu_op, carry, err, even, single} SHALL be written to the FIFO tail and state -> IDLE.
REQ-017 Latency: accept at edge k -> o_res_valid high after edge k+2 when FIFO was empty; max throughput one command per 3 cycles.
REQ-018 o_alu_a/b/op SHALL hold their values after CAPTURE until the next accept.
REQ-019 Opcode 2'b11 SHALL be accepted and processed identically; ALU outputs captured as-is.
REQ-020 o_res_valid SHALL equal (o_res_count != 0); o_res_data/op/flags SHALL show the head entry, zero when empty.
REQ-021 Pop = o_res_valid & i_res_ready at an edge; simultaneous pop and CAPTURE write SHALL leave o_res_count unchanged and preserve order.
REQ-022 A CAPTURE write SHALL never find the FIFO full (guaranteed by REQ-013); read/write pointers SHALL wrap modulo DEPTH.
REQ-023 o_busy SHALL be 1 in ISSUE and CAPTURE, 0 in IDLE.
REQ-024 o_err_cnt SHALL increment by 1 on each CAPTURE with i_alu_err=1, saturating at 8'hFF.
REQ-025 i_cmd_* changes while o_cmd_ready=0 SHALL have no effect.

Reset
REQ-026 On i_rst=1 the block SHALL immediately enter IDLE, empty the FIFO, and zero o_alu_a/b/op, o_res_*, o_err_cnt, o_res_count, o_busy.
REQ-027 Reset in ISSUE or CAPTURE SHALL abort the command with no FIFO write.
REQ-028 After i_rst deasserts, o_cmd_ready SHALL be 1 in the first cycle.

Verification (bench ties the team ALU to the o_alu_*/i_alu_* ports, BITS=8)
REQ-029 Sub: accept a=8'h05,b=8'h03,op=00 at edge k -> o_alu_a=8'h05 after k, o_res_valid=1 after k+2, o_res_data=8'h02, o_res_op=00.
REQ-030 Fill: hold i_res_ready=0, issue 4 commands -> o_res_count=4, o_cmd_ready=0; one pop -> o_cmd_ready=1 next cycle; FIFO order preserved.
REQ-031 Shift error: commands forcing i_alu_err=1 three times -> o_err_cnt=3, flags[2]=1 on those entries; 300 such -> o_err_cnt=8'hFF.
REQ-032 Concurrent: one entry queued, i_res_ready=1 during CAPTURE of next command -> o_res_count stays 1, head is the new result.
REQ-033 Reset in CAPTURE: assert i_rst mid-cycle -> o_busy=0, o_res_valid=0, o_res_count=0 immediately, no result emerges afterwards.
REQ-034 Opcode 11: accept op=2'b11 -> result entry written after 3 cycles with o_res_op=11 and data/flags equal to ALU outputs.
